// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions: NOP opcode, register-index width and the
// arbiter state encoding used by datapath_arbiter.
package fir_pkg;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam int         REG_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/datapath_arbiter_grant_timer.sv
// grant_timer: saturating count of consecutive cycles a grant has been held.
// `expired` is high while the count sits at TIMEOUT.
module grant_timer
  import fir_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Clear wins over enable; stop counting once the limit is reached.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/datapath_arbiter.sv
// datapath_arbiter: round-robin burst arbiter sharing one FIR datapath between
// two sequencing controllers. Non-owners see NOP; overflow is routed back to
// the owner only.
// Optional watchdog: define DATAPATH_ARBITER_WATCHDOG_EN to revoke grants held
// for TIMEOUT cycles and block the offender until it drops its request.
module datapath_arbiter
  import fir_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [1:0]                req,
  input  logic [1:0][2:0]           op_in,
  input  logic [1:0][REG_IDX_W-1:0] src1_in,
  input  logic [1:0][REG_IDX_W-1:0] src2_in,
  input  logic [1:0][REG_IDX_W-1:0] dest_in,
  input  logic [1:0][15:0]          ext1_in,
  input  logic [1:0][15:0]          ext2_in,
  input  logic                      overflow,
  output logic [1:0]                gnt,
  output logic [2:0]                op,
  output logic [REG_IDX_W-1:0]      src1,
  output logic [REG_IDX_W-1:0]      src2,
  output logic [REG_IDX_W-1:0]      dest,
  output logic [15:0]               ext_data1,
  output logic [15:0]               ext_data2,
  output logic [1:0]                ovf_out,
  output logic [1:0]                err_timeout
);

  arb_state_t state;
  logic       last;
  logic [1:0] req_eff;
  logic       expired;

`ifdef DATAPATH_ARBITER_WATCHDOG_EN
  logic [1:0] lock;
  logic [1:0] revoke;
  logic       hold;

  // Owner keeps the grant this cycle; anything else changes state.
  assign hold    = ((state == OWN0) && req[0] && !expired) ||
                   ((state == OWN1) && req[1] && !expired);
  assign revoke  = {(state == OWN1) && req[1] && expired,
                    (state == OWN0) && req[0] && expired};
  assign req_eff = req & ~lock;

  grant_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_grant_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (!hold),
    .en     (hold),
    .expired(expired)
  );
`else
  logic unused_cfg;

  assign unused_cfg  = ^{TIMEOUT, CNT_W};
  assign req_eff     = req;
  assign expired     = 1'b0;
  assign err_timeout = 2'b00;
`endif

  // Arbitration FSM with registered grant; `last` remembers the latest owner.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      gnt   <= 2'b00;
      last  <= 1'b1;
`ifdef DATAPATH_ARBITER_WATCHDOG_EN
      lock        <= 2'b00;
      err_timeout <= 2'b00;
`endif
    end else begin
`ifdef DATAPATH_ARBITER_WATCHDOG_EN
      // A request must go low for a cycle before a revoked requester competes.
      lock        <= (lock | revoke) & req;
      err_timeout <= revoke;
`endif
      case (state)
        IDLE: begin
          if ((req_eff == 2'b01) || ((req_eff == 2'b11) && last)) begin
            state <= OWN0;
            gnt   <= 2'b01;
            last  <= 1'b0;
          end else if (req_eff[1]) begin
            state <= OWN1;
            gnt   <= 2'b10;
            last  <= 1'b1;
          end
        end
        OWN0: begin
          if (!(req[0] && !expired)) begin
            if (req_eff[1]) begin
              state <= OWN1;
              gnt   <= 2'b10;
              last  <= 1'b1;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        OWN1: begin
          if (!(req[1] && !expired)) begin
            if (req_eff[0]) begin
              state <= OWN0;
              gnt   <= 2'b01;
              last  <= 1'b0;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Route the active owner's operation; a dropped request yields NOP at once.
  always_comb begin
    op        = OP_NOP;
    src1      = '0;
    src2      = '0;
    dest      = '0;
    ext_data1 = '0;
    ext_data2 = '0;
    if (gnt[0] && req[0]) begin
      op        = op_in[0];
      src1      = src1_in[0];
      src2      = src2_in[0];
      dest      = dest_in[0];
      ext_data1 = ext1_in[0];
      ext_data2 = ext2_in[0];
    end else if (gnt[1] && req[1]) begin
      op        = op_in[1];
      src1      = src1_in[1];
      src2      = src2_in[1];
      dest      = dest_in[1];
      ext_data1 = ext1_in[1];
      ext_data2 = ext2_in[1];
    end
  end

  assign ovf_out = {2{overflow}} & gnt & req;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Scoreboard bench for datapath_arbiter: a driver applies stimulus each cycle
// and queues the expected outputs from an owner/priority model; a monitor
// compares at the falling edge.
module tb_datapath_arbiter;

  localparam int TO = 4;
`ifdef DATAPATH_ARBITER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic [1:0]      req = 2'b00;
  logic [1:0][2:0] op_in = '0;
  logic [1:0][3:0] src1_in = '0, src2_in = '0, dest_in = '0;
  logic [1:0][15:0] ext1_in = '0, ext2_in = '0;
  logic            overflow = 1'b0;
  logic [1:0]      gnt, ovf_out, err_timeout;
  logic [2:0]      op;
  logic [3:0]      src1, src2, dest;
  logic [15:0]     ext_data1, ext_data2;

  datapath_arbiter #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .op_in(op_in),
    .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in),
    .ext1_in(ext1_in), .ext2_in(ext2_in), .overflow(overflow),
    .gnt(gnt), .op(op), .src1(src1), .src2(src2), .dest(dest),
    .ext_data1(ext_data1), .ext_data2(ext_data2),
    .ovf_out(ovf_out), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [2:0]  op;
    logic [3:0]  src1, src2, dest;
    logic [15:0] e1, e2;
    logic [1:0]  ovf, err;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: who owns the datapath, who won last, hold length, locks.
  int owner = -1;
  int last_m = 1;
  int hold = 0;
  logic [1:0] lock_m = 2'b00;
  logic [1:0] err_m = 2'b00;

  task automatic model_reset();
    owner = -1; last_m = 1; hold = 0; lock_m = 2'b00; err_m = 2'b00;
  endtask

  task automatic model_edge();
    logic [1:0] eff;
    eff = WD ? (req & ~lock_m) : req;
    err_m = 2'b00;
    if (owner < 0) begin
      if (eff == 2'b11) owner = 1 - last_m;
      else if (eff[0]) owner = 0;
      else if (eff[1]) owner = 1;
      if (owner >= 0) begin last_m = owner; hold = 0; end
    end else begin
      int o;
      bit expd;
      o = owner;
      expd = WD && (hold == TO);
      if (req[o] && !expd) begin
        hold = (hold < TO) ? hold + 1 : TO;
      end else begin
        if (req[o]) begin err_m[o] = 1'b1; lock_m[o] = 1'b1; end
        hold = 0;
        if (eff[1-o]) begin owner = 1 - o; last_m = owner; end
        else owner = -1;
      end
    end
    for (int i = 0; i < 2; i++) if (!req[i]) lock_m[i] = 1'b0;
  endtask

  task automatic push_expected();
    exp_t e;
    e = '0;
    e.gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    if (owner >= 0 && req[owner]) begin
      e.op = op_in[owner]; e.src1 = src1_in[owner]; e.src2 = src2_in[owner];
      e.dest = dest_in[owner]; e.e1 = ext1_in[owner]; e.e2 = ext2_in[owner];
      if (overflow) e.ovf[owner] = 1'b1;
    end
    e.err = err_m;
    q.push_back(e);
  endtask

  // One cycle of stimulus; rstv=0 asserts reset mid-cycle (no clock edge).
  task automatic tick(input logic [1:0] r, input logic ov, input logic rstv);
    @(posedge clk);
    if (n_rst) model_edge();
    #1;
    req = r;
    overflow = ov;
    for (int i = 0; i < 2; i++) begin
      op_in[i] = 3'($urandom); src1_in[i] = 4'($urandom);
      src2_in[i] = 4'($urandom); dest_in[i] = 4'($urandom);
      ext1_in[i] = 16'($urandom); ext2_in[i] = 16'($urandom);
    end
    #1;
    if (!rstv) begin n_rst = 1'b0; model_reset(); end
    else n_rst = 1'b1;
    push_expected();
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, req_v);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", 16'(gnt), 16'(e.gnt));
        chk("op", 16'(op), 16'(e.op));
        chk("src1", 16'(src1), 16'(e.src1));
        chk("src2", 16'(src2), 16'(e.src2));
        chk("dest", 16'(dest), 16'(e.dest));
        chk("ext_data1", ext_data1, e.e1);
        chk("ext_data2", ext_data2, e.e2);
        chk("ovf_out", 16'(ovf_out), 16'(e.ovf));
        chk("err_timeout", 16'(err_timeout), 16'(e.err));
      end
    end
  end

  initial begin
    // Reset state, then a single requester.
    repeat (3) tick(2'b00, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b1);
    tick(2'b01, 1'b0, 1'b1);
    repeat (4) tick(2'b01, 1'b0, 1'b1);
    repeat (2) tick(2'b00, 1'b0, 1'b1);

    // Fresh reset, simultaneous requests, handoff and alternating bursts.
    repeat (2) tick(2'b00, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b1);
    repeat (3) tick(2'b11, 1'b0, 1'b1);
    repeat (2) tick(2'b10, 1'b0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      repeat (3) tick(2'b11, 1'b0, 1'b1);
      tick((owner == 0) ? 2'b10 : 2'b01, 1'b0, 1'b1);
    end

    // Overflow routed to owner 1 only.
    repeat (3) tick(2'b10, 1'b1, 1'b1);
    tick(2'b11, 1'b1, 1'b1);

    // Asynchronous reset while requester 1 owns, then re-arbitrate.
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b1);
    repeat (3) tick(2'b11, 1'b0, 1'b1);

    // Long continuous contention (watchdog revokes or grant persists).
    repeat (2) tick(2'b00, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b1);
    repeat (100) tick(2'b11, 1'b0, 1'b1);
    repeat (2) tick(2'b10, 1'b0, 1'b1);
    repeat (12) tick(2'b11, 1'b0, 1'b1);
    tick(2'b00, 1'b0, 1'b1);

    // Randomized bursts with occasional resets.
    begin
      logic [1:0] r;
      r = 2'b00;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 3) == 0) r[0] = ~r[0];
        if ($urandom_range(0, 3) == 0) r[1] = ~r[1];
        tick(r, 1'($urandom), ($urandom_range(0, 199) != 0));
      end
    end
    tick(2'b00, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
